// File: rtl/ecap5_dproc_pkg.sv
// Shared constants and types for the ecap5 processor front end: fixed vector
// addresses, the prefetch FSM state encoding and jump-target selection.
package ecap5_dproc_pkg;

  localparam logic [31:0] BOOT_ADDRESS      = 32'h0000_0000;
  localparam logic [31:0] INTERRUPT_ADDRESS = 32'h0000_1000;
  localparam logic [31:0] DEBUG_ADDRESS     = 32'h0000_8000;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifm_prefetch_state_t;

  // Debug beats interrupt beats branch when several arrive in one cycle.
  function automatic logic [31:0] jump_target(input logic        drq,
                                              input logic        irq,
                                              input logic [31:0] jmp_target);
    logic [31:0] result;
    result = jmp_target;
    if (drq) begin
      result = DEBUG_ADDRESS;
    end else if (irq) begin
      result = INTERRUPT_ADDRESS;
    end
    return result;
  endfunction

endpackage

// File: rtl/ifm_prefetch_fifo.sv
// Synchronous FIFO with flush. Holds fetched {pc, instr} entries in the
// prefetch stage and, at 32-bit width, the addresses of in-flight requests.
module ifm_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign count    = cnt;
  assign data_out = mem[rd_ptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ifm_prefetch.sv
// Instruction fetch stage with a pipelined Wishbone master and prefetch buffer.
// Optional macro ECAP5_IFM_BYPASS_EN forwards an ack straight to decode when the buffer is empty.
module ifm_prefetch
  import ecap5_dproc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        drq_i,
  input  logic        irq_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ifm_prefetch_state_t state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic             stb_q, stb_d;
  logic [31:0]      adr_q, adr_d;

  logic             jump;
  logic [31:0]      target;
  logic             accept;
  logic             ack;
  logic             drop;
  logic             bypass;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, fifo_count_d;
  logic [63:0]      fifo_head;

  logic             aq_full, aq_empty;
  logic [CNT_W-1:0] outstanding, outstanding_d;
  logic [31:0]      aq_head;
  logic [CNT_W:0]   level_d;

  assign jump   = drq_i || irq_i || jmp_i;
  assign target = jump_target(drq_i, irq_i, jmp_target_i);

  // Every accepted request has its address in the queue, so an ack with an
  // empty queue is spurious and ignored.
  assign accept = stb_q && !wb_stall_i;
  assign ack    = wb_ack_i && !aq_empty;
  assign drop   = (discard_q != '0);

`ifdef ECAP5_IFM_BYPASS_EN
  assign bypass = ack && fifo_empty && !drop && !jump;
`else
  assign bypass = 1'b0;
`endif

  // Decode handshake: an entry is offered while output_valid_o is high and
  // leaves exactly on a cycle where output_valid_o && output_ready_i.
  assign fifo_pop  = output_ready_i && !fifo_empty;
  assign fifo_push = ack && !drop && !jump && !(bypass && output_ready_i) &&
                     (!fifo_full || fifo_pop);

  assign output_valid_o = !fifo_empty || bypass;
  assign instr_o        = bypass ? wb_dat_i : fifo_head[31:0];
  assign pc_o           = bypass ? aq_head  : fifo_head[63:32];

  assign wb_adr_o = adr_q;
  assign wb_stb_o = stb_q;
  assign wb_cyc_o = stb_q || (outstanding != '0);
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;

  ifm_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_addr_queue (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (1'b0),
    .push     (accept),
    .pop      (ack),
    .data_in  (fetch_pc_q),
    .data_out (aq_head),
    .full     (aq_full),
    .empty    (aq_empty),
    .count    (outstanding)
  );

  ifm_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_instr_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (jump),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .data_in  ({aq_head, wb_dat_i}),
    .data_out (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    outstanding_d = outstanding;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    fifo_count_d  = fifo_count;
    state_d       = state_q;
    stb_d         = 1'b0;
    adr_d         = adr_q;

    if (accept && !ack) begin
      outstanding_d = outstanding + CNT_W'(1);
    end else if (!accept && ack) begin
      outstanding_d = outstanding - CNT_W'(1);
    end

    if (ack && drop) begin
      discard_d = discard_q - CNT_W'(1);
    end

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Everything still in flight after this cycle belongs to the old stream.
    if (jump) begin
      discard_d  = outstanding_d;
      fetch_pc_d = target;
    end

    if (jump) begin
      fifo_count_d = '0;
    end else if (fifo_push && !fifo_pop) begin
      fifo_count_d = fifo_count + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      fifo_count_d = fifo_count - CNT_W'(1);
    end

    case (state_q)
      START:      state_d = RUN;
      RUN, DRAIN: state_d = (discard_d != '0) ? DRAIN : RUN;
      default:    state_d = START;
    endcase

    // Buffered plus in-flight entries never exceed DEPTH, so every response
    // has a slot waiting for it. A stalled request stays put because this
    // level cannot rise without an accept.
    level_d = {1'b0, fifo_count_d} + {1'b0, outstanding_d};
    stb_d   = !jump && (state_d == RUN) && (level_d < (CNT_W + 1)'(DEPTH)) &&
              !(aq_full && !ack);
    if (stb_d) begin
      adr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= START;
      fetch_pc_q <= BOOT_ADDRESS;
      discard_q  <= '0;
      stb_q      <= 1'b0;
      adr_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      stb_q      <= stb_d;
      adr_q      <= adr_d;
    end
  end

endmodule
